// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite command subsystem: response codes, master FSM states and
// the queued command record (sized for the widest supported configuration).
package axi4_lite_pkg;

    localparam int MAX_ADDR_WIDTH = 64;
    localparam int MAX_DATA_WIDTH = 64;
    localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } mst_state_t;

    typedef struct packed {
        logic                      write;
        logic [MAX_ADDR_WIDTH-1:0] addr;
        logic [MAX_DATA_WIDTH-1:0] wdata;
        logic [MAX_STRB_WIDTH-1:0] wstrb;
    } cmd_t;

    function automatic resp_t resp_of(input logic ok);
        return ok ? OKAY : SLVERR;
    endfunction

endpackage

// File: rtl/axi4_lite_regfile_slave.sv
// Byte-strobed AXI4-Lite register-file slave with registered single-cycle ready pulses.
// With AXI4_LITE_ID_REG_EN defined the last register is a read-only ID word.
module axi4_lite_regfile_slave
    import axi4_lite_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 32,
    parameter int          NUM_REGS   = 16,
    parameter logic [31:0] ID_VALUE   = 32'hA41C_0001
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    bvalid,
    input  logic                    bready,
    output resp_t                   bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output resp_t                   rresp
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] rd_value;

    // Address decode and read-data selection for the current request.
    always_comb begin
        wr_idx  = awaddr >> BYTE_SHIFT;
        rd_idx  = araddr >> BYTE_SHIFT;
        rd_ok   = (rd_idx < ADDR_WIDTH'(NUM_REGS));
        wr_fire = awvalid && awready && wvalid && wready;
        rd_fire = arvalid && arready;
`ifdef AXI4_LITE_ID_REG_EN
        wr_ok = (wr_idx < ADDR_WIDTH'(NUM_REGS)) && (wr_idx != LAST_IDX);
`else
        wr_ok = (wr_idx < ADDR_WIDTH'(NUM_REGS));
`endif
        if (rd_ok) begin
            rd_value = regs[rd_idx[IDX_WIDTH-1:0]];
        end else begin
            rd_value = {DATA_WIDTH{1'b0}};
        end
`ifdef AXI4_LITE_ID_REG_EN
        if (rd_idx == LAST_IDX) begin
            rd_value = DATA_WIDTH'(ID_VALUE);
        end else begin
            rd_value = rd_value;
        end
`endif
    end

    // Handshake generation, register updates and response channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= {DATA_WIDTH{1'b0}};
            rresp   <= OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            // The !awready term keeps the pulse to one cycle while valids are still high.
            awready <= awvalid && wvalid && !bvalid && !awready;
            wready  <= awvalid && wvalid && !bvalid && !awready;
            arready <= arvalid && !rvalid && !arready;
            if (wr_fire) begin
                bvalid <= 1'b1;
                bresp  <= resp_of(wr_ok);
                if (wr_ok) begin
                    for (int b = 0; b < STRB_WIDTH; b++) begin
                        if (wstrb[b]) begin
                            regs[wr_idx[IDX_WIDTH-1:0]][8*b +: 8] <= wdata[8*b +: 8];
                        end
                    end
                end
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
            if (rd_fire) begin
                rvalid <= 1'b1;
                rdata  <= rd_value;
                rresp  <= resp_of(rd_ok);
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi4_lite_cmd_subsys.sv
// Command FIFO plus single-outstanding AXI4-Lite master driving the internal register file.
// Optional read-only ID register selected with AXI4_LITE_ID_REG_EN.
module axi4_lite_cmd_subsys
    import axi4_lite_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 32,
    parameter int          NUM_REGS   = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] ID_VALUE   = 32'hA41C_0001
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    busy
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_WIDTH  = $clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH  = PTR_WIDTH + 1;

    cmd_t                  fifo_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic                  push;
    logic                  pop;
    cmd_t                  head;
    mst_state_t            state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [STRB_WIDTH-1:0] cur_wstrb;
    logic                  awvalid, awready, wvalid, wready, bvalid, bready;
    logic                  arvalid, arready, rvalid, rready;
    resp_t                 bresp, rresp;
    logic [DATA_WIDTH-1:0] rdata;

    // FIFO status and the pop request from an idle master.
    always_comb begin
        cmd_ready = (count != CNT_WIDTH'(FIFO_DEPTH));
        push      = cmd_valid && cmd_ready;
        pop       = (state == IDLE) && (count != CNT_WIDTH'(0));
        head      = fifo_mem[rd_ptr];
        busy      = (count != CNT_WIDTH'(0)) || (state != IDLE);
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge ACLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{write: cmd_write,
                                  addr:  MAX_ADDR_WIDTH'(cmd_addr),
                                  wdata: MAX_DATA_WIDTH'(cmd_wdata),
                                  wstrb: MAX_STRB_WIDTH'(cmd_wstrb)};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr <= PTR_WIDTH'(0);
            rd_ptr <= PTR_WIDTH'(0);
            count  <= CNT_WIDTH'(0);
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            if (push && !pop) begin
                count <= count + CNT_WIDTH'(1);
            end else if (pop && !push) begin
                count <= count - CNT_WIDTH'(1);
            end
        end
    end

    // Master FSM: one AXI transaction at a time, all outputs registered.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= IDLE;
            cur_addr  <= {ADDR_WIDTH{1'b0}};
            cur_wdata <= {DATA_WIDTH{1'b0}};
            cur_wstrb <= {STRB_WIDTH{1'b0}};
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= {DATA_WIDTH{1'b0}};
            rsp_resp  <= OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_addr  <= head.addr[ADDR_WIDTH-1:0];
                        cur_wdata <= head.wdata[DATA_WIDTH-1:0];
                        cur_wstrb <= head.wstrb[STRB_WIDTH-1:0];
                        if (head.write) begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR_REQ;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    // A channel is finished once its valid is already low or handshaking now.
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b1;
                        rsp_rdata <= {DATA_WIDTH{1'b0}};
                        rsp_resp  <= bresp;
                        state     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        rsp_rdata <= (rresp == OKAY) ? rdata : {DATA_WIDTH{1'b0}};
                        rsp_resp  <= rresp;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_write <= 1'b0;
                        rsp_rdata <= {DATA_WIDTH{1'b0}};
                        rsp_resp  <= OKAY;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    axi4_lite_regfile_slave #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ID_VALUE   (ID_VALUE)
    ) u_slave (
        .clk     (ACLK),
        .rst     (ARESET),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (cur_addr),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (cur_wdata),
        .wstrb   (cur_wstrb),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp),
        .arvalid (arvalid),
        .arready (arready),
        .araddr  (cur_addr),
        .rvalid  (rvalid),
        .rready  (rready),
        .rdata   (rdata),
        .rresp   (rresp)
    );

endmodule

// File: tb/tb_axi4_lite_cmd_subsys.sv
// Self-checking bench for axi4_lite_cmd_subsys: directed steps plus random traffic
// checked against a behavioural register-file model (honours AXI4_LITE_ID_REG_EN).
module tb_axi4_lite_cmd_subsys;

    localparam int NR = 16;
`ifdef AXI4_LITE_ID_REG_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic [3:0]  cmd_wstrb = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy;

    always #5 ACLK = ~ACLK;

    axi4_lite_cmd_subsys dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .busy      (busy)
    );

    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_regs [NR];
    exp_t        exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: word index = addr/4, out-of-range -> SLVERR, strobed byte writes.
    function automatic exp_t model_apply(input logic wr, input logic [31:0] addr,
                                         input logic [31:0] data, input logic [3:0] strb);
        exp_t e;
        int   idx;
        idx     = int'(addr / 32'd4);
        e.write = wr;
        e.rdata = 32'd0;
        e.resp  = 2'b00;
        if (idx >= NR) begin
            e.resp = 2'b10;
        end else if (wr) begin
            if (ID_EN && idx == NR - 1) begin
                e.resp = 2'b10;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
            end
        end else begin
            e.rdata = (ID_EN && idx == NR - 1) ? 32'hA41C_0001 : model_regs[idx];
        end
        return e;
    endfunction

    // Entered and left at a negedge; offers one command for one clock edge.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output logic accepted);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        accepted  = cmd_ready;
        if (accepted) exp_q.push_back(model_apply(wr, addr, data, strb));
        @(posedge ACLK);
        @(negedge ACLK);
        cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for a response, checks it against the queue head and consumes it.
    task automatic recv(input string tag, input int want_lat);
        exp_t e;
        int   k;
        k = 1;
        while (!rsp_valid && k < 60) begin
            @(negedge ACLK);
            k++;
        end
        check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        if (rsp_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_write"}, 64'(rsp_write), 64'(e.write));
            check({tag, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
            check({tag, "_resp"}, 64'(rsp_resp), 64'(e.resp));
            if (want_lat > 0) check({tag, "_latency"}, 64'(k), 64'(want_lat));
            @(posedge ACLK);
            @(negedge ACLK);
        end
    endtask

    task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
        logic acc;
        send(wr, addr, data, strb, acc);
        check({tag, "_accept"}, 64'(acc), 64'd1);
        recv(tag, 5);
    endtask

    initial begin
        logic acc;
        int   n_acc;
        int   seen;
        for (int i = 0; i < NR; i++) model_regs[i] = 32'd0;

        // Reset, with a command offered that must be ignored.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0010;
        cmd_wdata = 32'hFFFF_FFFF;
        cmd_wstrb = 4'hF;
        repeat (3) @(negedge ACLK);
        ARESET    = 1'b0;
        cmd_valid = 1'b0;
        check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("reset_rsp_resp", 64'(rsp_resp), 64'd0);
        check("reset_rsp_write", 64'(rsp_write), 64'd0);

        // Directed register accesses.
        txn("wr_full", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        txn("rd_full", 1'b0, 32'h10, 32'h0, 4'h0);
        txn("wr_part", 1'b1, 32'h10, 32'h1122_3344, 4'b0101);
        txn("rd_part", 1'b0, 32'h10, 32'h0, 4'h0);
        check("model_part", 64'(model_regs[4]), 64'h0000_0000_DE22_BE44);
        txn("rd_oob", 1'b0, 32'h100, 32'h0, 4'h0);
        txn("wr_oob", 1'b1, 32'h100, 32'h5555_AAAA, 4'hF);
        txn("rd_last", 1'b0, 32'h3C, 32'h0, 4'h0);
        txn("wr_last", 1'b1, 32'h3C, 32'h0BAD_F00D, 4'hF);
        txn("rd_last2", 1'b0, 32'h3C, 32'h0, 4'h0);
        txn("wr_nostrb", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0);
        txn("rd_nostrb", 1'b0, 32'h10, 32'h0, 4'h0);

        // Random traffic, including unaligned and out-of-range addresses.
        for (int i = 0; i < 40; i++) begin
            txn("rand", 1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'h4F)),
                32'($urandom), 4'($urandom_range(0, 15)));
        end

        // Back-pressure: park one response, then offer six more commands.
        rsp_ready = 1'b0;
        send(1'b1, 32'h8, 32'($urandom), 4'hF, acc);
        check("bp_first_accept", 64'(acc), 64'd1);
        seen = 0;
        while (!rsp_valid && seen < 40) begin
            @(negedge ACLK);
            seen++;
        end
        check("bp_parked", 64'(rsp_valid), 64'd1);
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(1'($urandom_range(0, 1)), 32'(4 * i), 32'($urandom), 4'hF, acc);
            if (acc) n_acc++;
        end
        check("bp_accepted", 64'(n_acc), 64'd4);
        check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        check("bp_busy", 64'(busy), 64'd1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) recv("bp_order", -1);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Reset while the write sits in WR_RESP (4th cycle after acceptance).
        send(1'b1, 32'h10, 32'hCAFE_F00D, 4'hF, acc);
        repeat (3) @(negedge ACLK);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NR; i++) model_regs[i] = 32'd0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) seen++;
            @(negedge ACLK);
        end
        check("rst_mid_no_rsp", 64'(seen), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
        txn("rst_mid_readback", 1'b0, 32'h10, 32'h0, 4'h0);
        txn("rst_mid_last", 1'b0, 32'h3C, 32'h0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
